// File: rtl/ariane_axi_pkg.sv
// AXI4 channel and bundle types shared by the core's bus fabric.
// Sized for the 64-bit data path with 4-bit IDs.
package ariane_axi;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 64;
  localparam int unsigned DataW = 64;
  localparam int unsigned UserW = 1;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
    logic [5:0]       atop;
    logic [UserW-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataW-1:0]   data;
    logic [DataW/8-1:0] strb;
    logic               last;
    logic [UserW-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [1:0]       resp;
    logic [UserW-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
    logic [UserW-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
    logic [UserW-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/axi_rr_pick.sv
// Round-robin picker: first set bit of valid_i at or after ptr_i.
// Purely combinational; the caller owns the pointer register.
module axi_rr_pick #(
  parameter int unsigned NumMst = 2,
  parameter int unsigned IdxW   = $clog2(NumMst)
) (
  input  logic [NumMst-1:0] valid_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              any_o,
  output logic [IdxW-1:0]   idx_o
);

  function automatic logic [IdxW-1:0] wrap(
    input logic [IdxW-1:0] p,
    input int unsigned     o
  );
    int unsigned s;
    s = (32'(p) + o) % NumMst;
    return IdxW'(s);
  endfunction

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < NumMst; i++) begin
      if (!any_o && valid_i[wrap(ptr_i, i)]) begin
        any_o = 1'b1;
        idx_o = wrap(ptr_i, i);
      end
    end
  end

endmodule

// File: rtl/axi_txn_arbiter.sv
// N:1 AXI arbiter, one transaction at a time per direction.
// Write and read sequencers run independently with own RR pointers.
module axi_txn_arbiter
  import ariane_axi::*;
#(
  parameter int unsigned NumMst = 2,
  parameter int unsigned IdxW   = $clog2(NumMst)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  req_t  [NumMst-1:0]  mst_req_i,
  output resp_t [NumMst-1:0]  mst_resp_o,
  output req_t                slv_req_o,
  input  resp_t               slv_resp_i
);

  typedef enum logic [1:0] {
    W_IDLE, W_AW, W_DATA, W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE, R_AR, R_DATA
  } r_state_e;

  w_state_e w_q, w_d;
  r_state_e r_q, r_d;

  logic [IdxW-1:0]   w_gnt_q, w_ptr_q, w_win;
  logic [IdxW-1:0]   r_gnt_q, r_ptr_q, r_win;
  logic              w_any, r_any;
  logic [NumMst-1:0] aw_vld, ar_vld;
  logic              aw_hs, w_hs, b_hs;
  logic              ar_hs, r_hs;

  function automatic logic [IdxW-1:0] nxt(
    input logic [IdxW-1:0] i
  );
    return (32'(i) == NumMst - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NumMst; i++) begin
      aw_vld[i] = mst_req_i[i].aw_valid;
      ar_vld[i] = mst_req_i[i].ar_valid;
    end
  end

  axi_rr_pick #(
    .NumMst (NumMst),
    .IdxW   (IdxW)
  ) u_aw_pick (
    .valid_i (aw_vld),
    .ptr_i   (w_ptr_q),
    .any_o   (w_any),
    .idx_o   (w_win)
  );

  axi_rr_pick #(
    .NumMst (NumMst),
    .IdxW   (IdxW)
  ) u_ar_pick (
    .valid_i (ar_vld),
    .ptr_i   (r_ptr_q),
    .any_o   (r_any),
    .idx_o   (r_win)
  );

  // Handshakes seen on the downstream side, qualified by phase.
  assign aw_hs = (w_q == W_AW) &&
                 mst_req_i[w_gnt_q].aw_valid &&
                 slv_resp_i.aw_ready;
  assign w_hs  = (w_q == W_DATA) &&
                 mst_req_i[w_gnt_q].w_valid &&
                 slv_resp_i.w_ready;
  assign b_hs  = (w_q == W_RESP) &&
                 slv_resp_i.b_valid &&
                 mst_req_i[w_gnt_q].b_ready;
  assign ar_hs = (r_q == R_AR) &&
                 mst_req_i[r_gnt_q].ar_valid &&
                 slv_resp_i.ar_ready;
  assign r_hs  = (r_q == R_DATA) &&
                 slv_resp_i.r_valid &&
                 mst_req_i[r_gnt_q].r_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_q     <= W_IDLE;
      w_gnt_q <= '0;
      w_ptr_q <= '0;
    end else begin
      w_q <= w_d;
      if (w_q == W_IDLE && w_any) begin
        w_gnt_q <= w_win;
        w_ptr_q <= nxt(w_win);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_q     <= R_IDLE;
      r_gnt_q <= '0;
      r_ptr_q <= '0;
    end else begin
      r_q <= r_d;
      if (r_q == R_IDLE && r_any) begin
        r_gnt_q <= r_win;
        r_ptr_q <= nxt(r_win);
      end
    end
  end

  always_comb begin
    w_d = w_q;
    unique case (w_q)
      W_IDLE: if (w_any) w_d = W_AW;
      W_AW:   if (aw_hs) w_d = W_DATA;
      W_DATA: if (w_hs && mst_req_i[w_gnt_q].w.last)
                w_d = W_RESP;
      W_RESP: if (b_hs) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_d = r_q;
    unique case (r_q)
      R_IDLE: if (r_any) r_d = R_AR;
      R_AR:   if (ar_hs) r_d = R_DATA;
      R_DATA: if (r_hs && slv_resp_i.r.last)
                r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  // Payloads always follow the grant; only valid/ready are gated.
  always_comb begin
    slv_req_o    = '0;
    slv_req_o.aw = mst_req_i[w_gnt_q].aw;
    slv_req_o.w  = mst_req_i[w_gnt_q].w;
    slv_req_o.ar = mst_req_i[r_gnt_q].ar;
    for (int i = 0; i < NumMst; i++) begin
      mst_resp_o[i]   = '0;
      mst_resp_o[i].b = slv_resp_i.b;
      mst_resp_o[i].r = slv_resp_i.r;
    end
    unique case (w_q)
      W_AW: begin
        slv_req_o.aw_valid = mst_req_i[w_gnt_q].aw_valid;
        mst_resp_o[w_gnt_q].aw_ready = slv_resp_i.aw_ready;
      end
      W_DATA: begin
        slv_req_o.w_valid = mst_req_i[w_gnt_q].w_valid;
        mst_resp_o[w_gnt_q].w_ready = slv_resp_i.w_ready;
      end
      W_RESP: begin
        slv_req_o.b_ready = mst_req_i[w_gnt_q].b_ready;
        mst_resp_o[w_gnt_q].b_valid = slv_resp_i.b_valid;
      end
      default: ;
    endcase
    unique case (r_q)
      R_AR: begin
        slv_req_o.ar_valid = mst_req_i[r_gnt_q].ar_valid;
        mst_resp_o[r_gnt_q].ar_ready = slv_resp_i.ar_ready;
      end
      R_DATA: begin
        slv_req_o.r_ready = mst_req_i[r_gnt_q].r_ready;
        mst_resp_o[r_gnt_q].r_valid = slv_resp_i.r_valid;
      end
      default: ;
    endcase
  end

  a_no_atop: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (w_q == W_AW && mst_req_i[w_gnt_q].aw_valid)
      |-> (mst_req_i[w_gnt_q].aw.atop == '0)
  );

endmodule
